// File: rtl/dataflow_switch_ctrl_pkg.sv
// Shared definitions for the two-source D-PHY TX data-flow switch controller.
//   dfs_state_e       : handover FSM states (own, drain, guard, switch)
//   LP11              : lane-0 LP level pair that marks a stopped lane
//   DRAIN_IDLE_CYCLES : consecutive idle samples needed before the guard interval
package dfs_pkg;

    typedef enum logic [1:0] {
        StOwn    = 2'd0,
        StDrain  = 2'd1,
        StGuard  = 2'd2,
        StSwitch = 2'd3
    } dfs_state_e;

    localparam logic [1:0]  LP11              = 2'b11;
    localparam int unsigned DRAIN_IDLE_CYCLES = 2;

endpackage

// File: rtl/dataflow_switch_ctrl_if.sv
// Bus between the two TX sources / datapath and the switch controller.
//   master : source side (drives requests and per-source lane status, sees grants)
//   slave  : controller side (samples requests and lane status, drives select/grants)
interface dataflow_switch_ctrl_if;
    import dfs_pkg::*;

    logic       req_a;
    logic       req_b;
    logic       hs_clk_en_a;
    logic       hs_clk_en_b;
    logic       hs_data_en_a;
    logic       hs_data_en_b;
    logic [1:0] lp0_out_a;
    logic [1:0] lp0_out_b;
    logic       i_state;
    logic       grant_a;
    logic       grant_b;
    logic       force_lp11;
    logic       busy;
    logic       timeout_err;

    modport master (
        output req_a, req_b, hs_clk_en_a, hs_clk_en_b, hs_data_en_a, hs_data_en_b,
               lp0_out_a, lp0_out_b,
        input  i_state, grant_a, grant_b, force_lp11, busy, timeout_err
    );

    modport slave (
        input  req_a, req_b, hs_clk_en_a, hs_clk_en_b, hs_data_en_a, hs_data_en_b,
               lp0_out_a, lp0_out_b,
        output i_state, grant_a, grant_b, force_lp11, busy, timeout_err
    );

endinterface

// File: rtl/dataflow_switch_ctrl_idle_detect.sv
// Per-source lane idle qualifier: lane is idle when HS clock and data are both
// disabled and lane 0 sits at LP-11.
//   hs_clk_en_i  : HS clock enable of the source
//   hs_data_en_i : HS data enable of the source
//   lp0_out_i    : lane-0 LP levels of the source
//   idle_o       : combinational idle indication
module dfs_idle_detect
    import dfs_pkg::*;
(
    input  logic       hs_clk_en_i,
    input  logic       hs_data_en_i,
    input  logic [1:0] lp0_out_i,
    output logic       idle_o
);

    assign idle_o = !hs_clk_en_i && !hs_data_en_i && (lp0_out_i == LP11);

endmodule

// File: rtl/dataflow_switch_ctrl.sv
// A/B select sequencer for the two-source MIPI D-PHY TX data-flow switch.
// Ownership moves only after the owner has released and sits idle in LP-11,
// followed by a guard interval of forced LP-11.
//   byte_clk : byte clock, all state on its rising edge
//   reset_n  : asynchronous active-low reset (ownership returns to A at once)
//   bus      : slave side of dataflow_switch_ctrl_if (requests, lane status,
//              i_state select, grants, force_lp11, busy, timeout_err)
// Optional build macro DFS_FORCE_TIMEOUT_EN: forces a handover when both sources
// have requested for TIMEOUT_CYCLES and sets a sticky timeout_err.
module dataflow_switch_ctrl
    import dfs_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input logic                    byte_clk,
    input logic                    reset_n,
    dataflow_switch_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] GuardLast = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [1:0]       IdleLast  = 2'(DRAIN_IDLE_CYCLES - 1);

    dfs_state_e       state_q, state_d;
    logic [1:0]       idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
    logic             i_state_q, i_state_d;
    logic             grant_a_q, grant_b_q;
    logic             force_lp11_q, busy_q;

    logic idle_a, idle_b;
    logic req_own, req_oth, owner_idle;

    dfs_idle_detect u_idle_a (
        .hs_clk_en_i  (bus.hs_clk_en_a),
        .hs_data_en_i (bus.hs_data_en_a),
        .lp0_out_i    (bus.lp0_out_a),
        .idle_o       (idle_a)
    );

    dfs_idle_detect u_idle_b (
        .hs_clk_en_i  (bus.hs_clk_en_b),
        .hs_data_en_i (bus.hs_data_en_b),
        .lp0_out_i    (bus.lp0_out_b),
        .idle_o       (idle_b)
    );

    assign req_own    = i_state_q ? bus.req_b : bus.req_a;
    assign req_oth    = i_state_q ? bus.req_a : bus.req_b;
    assign owner_idle = i_state_q ? idle_b : idle_a;

`ifdef DFS_FORCE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q;
    logic             both_req, tmo_hit;

    assign both_req = bus.req_a && bus.req_b;
    assign tmo_hit  = (state_q == StOwn) && both_req && (tmo_cnt_q >= TmoLast) && owner_idle;

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StOwn && both_req) begin
            tmo_cnt_d = (tmo_cnt_q == CntMax) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    logic tmo_hit;
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        guard_cnt_d = guard_cnt_q;
        i_state_d   = i_state_q;
        unique case (state_q)
            StOwn: begin
                // A forced handover is otherwise identical to a voluntary release.
                if ((req_oth && !req_own && owner_idle) || tmo_hit) begin
                    state_d    = StDrain;
                    idle_cnt_d = '0;
                end
            end
            StDrain: begin
                if (!req_oth) begin
                    state_d = StOwn;
                end else if (!owner_idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IdleLast) begin
                    state_d     = StGuard;
                    idle_cnt_d  = '0;
                    guard_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 2'd1;
                end
            end
            StGuard: begin
                if (guard_cnt_q == GuardLast) begin
                    state_d = StSwitch;
                end else if (guard_cnt_q != CntMax) begin
                    guard_cnt_d = guard_cnt_q + CNT_W'(1);
                end
            end
            StSwitch: begin
                i_state_d = !i_state_q;
                state_d   = StOwn;
            end
            default: state_d = StOwn;
        endcase
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StOwn;
            idle_cnt_q   <= '0;
            guard_cnt_q  <= '0;
            i_state_q    <= 1'b0;
            grant_a_q    <= 1'b1;
            grant_b_q    <= 1'b0;
            force_lp11_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            i_state_q    <= i_state_d;
            // Grant needs one settled OWN cycle, so it trails a select change by a cycle.
            grant_a_q    <= (state_q == StOwn) && (state_d == StOwn) && !i_state_q;
            grant_b_q    <= (state_q == StOwn) && (state_d == StOwn) && i_state_q;
            force_lp11_q <= (state_d != StOwn);
            busy_q       <= (state_d != StOwn);
        end
    end

    assign bus.i_state    = i_state_q;
    assign bus.grant_a    = grant_a_q;
    assign bus.grant_b    = grant_b_q;
    assign bus.force_lp11 = force_lp11_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dataflow_switch_ctrl.sv
// Directed bench for dataflow_switch_ctrl (GUARD_CYCLES=16, TIMEOUT_CYCLES=200).
// Table of single-cycle OWN-state decisions plus hand-written handover sequences.
module tb_dataflow_switch_ctrl;

    logic byte_clk = 1'b0;
    logic reset_n;

    always #5 byte_clk = ~byte_clk;

    dataflow_switch_ctrl_if bus ();

    dataflow_switch_ctrl #(
        .GUARD_CYCLES   (16),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .byte_clk (byte_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       ra;
        logic       rb;
        logic       ca;
        logic       da;
        logic [1:0] la;
        logic       exp_drain;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic is, input logic ga,
                              input logic gb, input logic fl, input logic bz);
        check({name, ".i_state"},    {7'd0, bus.i_state},    {7'd0, is});
        check({name, ".grant_a"},    {7'd0, bus.grant_a},    {7'd0, ga});
        check({name, ".grant_b"},    {7'd0, bus.grant_b},    {7'd0, gb});
        check({name, ".force_lp11"}, {7'd0, bus.force_lp11}, {7'd0, fl});
        check({name, ".busy"},       {7'd0, bus.busy},       {7'd0, bz});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge byte_clk);
        #1;
    endtask

    task automatic drive_a(input logic ca, input logic da, input logic [1:0] la);
        bus.hs_clk_en_a  = ca;
        bus.hs_data_en_a = da;
        bus.lp0_out_a    = la;
    endtask

    task automatic drive_b(input logic cb, input logic db, input logic [1:0] lb);
        bus.hs_clk_en_b  = cb;
        bus.hs_data_en_b = db;
        bus.lp0_out_b    = lb;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        //           ra    rb    ca    da    la     drain
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};

        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        drive_a(1'b0, 1'b0, 2'b00);
        drive_b(1'b0, 1'b0, 2'b00);
        do_reset();

        // Reset state held with no requests.
        for (int i = 0; i < 50; i++) begin
            check_outs($sformatf("reset_hold[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("reset_hold.timeout_err", {7'd0, bus.timeout_err}, 8'd0);
            step(1);
        end

        // OWN-state decision table; B lane kept busy so only A's status may matter.
        drive_b(1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 9; i++) begin
            bus.req_a = vecs[i].ra;
            bus.req_b = vecs[i].rb;
            drive_a(vecs[i].ca, vecs[i].da, vecs[i].la);
            step(1);
            check($sformatf("vec[%0d].busy", i), {7'd0, bus.busy}, {7'd0, vecs[i].exp_drain});
            check($sformatf("vec[%0d].force", i), {7'd0, bus.force_lp11},
                  {7'd0, vecs[i].exp_drain});
            check($sformatf("vec[%0d].grant_a", i), {7'd0, bus.grant_a},
                  {7'd0, !vecs[i].exp_drain});
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
            drive_a(1'b0, 1'b0, 2'b11);
            step(3);
            check_outs($sformatf("vec[%0d].restore", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Full A->B handover: 21 cycles from the switch condition to grant_b.
        bus.req_b = 1'b1;
        step(1);
        check_outs("ho.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(18);
        check_outs("ho.switch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1);
        check_outs("ho.sel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("ho.grant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // No requests: B keeps the lane.
        bus.req_b = 1'b0;
        step(10);
        check_outs("retain_b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // B->A handover interrupted by reset mid-guard.
        drive_b(1'b0, 1'b0, 2'b11);
        bus.req_a = 1'b1;
        step(1);
        check_outs("b2a.drain", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(5);
        check_outs("b2a.guard", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.req_a = 1'b0;
        #2;
        reset_n = 1'b1;
        step(1);
        check_outs("post_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort: req_b drops during DRAIN.
        drive_a(1'b0, 1'b0, 2'b11);
        bus.req_b = 1'b1;
        step(1);
        check_outs("abort.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.req_b = 1'b0;
        step(1);
        check_outs("abort.own", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("abort.grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(25);
        check_outs("abort.noguard", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // One-cycle HS data pulse in the second DRAIN cycle restarts the idle check.
        bus.req_b = 1'b1;
        step(2);
        bus.hs_data_en_a = 1'b1;
        step(1);
        check_outs("pulse.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.hs_data_en_a = 1'b0;
        step(18);
        check_outs("pulse.switch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1);
        check_outs("pulse.sel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("pulse.grant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Owner A never releases while B requests.
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        do_reset();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
`ifdef DFS_FORCE_TIMEOUT_EN
        step(199);
        check_outs("tmo.pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("tmo.pre.err", {7'd0, bus.timeout_err}, 8'd0);
        step(1);
        check_outs("tmo.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("tmo.err", {7'd0, bus.timeout_err}, 8'd1);
        step(19);
        check_outs("tmo.sel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo.err_sticky", {7'd0, bus.timeout_err}, 8'd1);
`else
        begin
            logic busy_seen;
            busy_seen = 1'b0;
            for (int i = 0; i < 500; i++) begin
                step(1);
                busy_seen = busy_seen | bus.busy;
            end
            check("hold.busy_seen", {7'd0, busy_seen}, 8'd0);
            check_outs("hold.end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("hold.timeout_err", {7'd0, bus.timeout_err}, 8'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dataflow_switch_ctrl.md
Name: dataflow_switch_ctrl

Overview:
Sequences the A/B select of the two-source MIPI D-PHY TX data-flow switch so ownership changes only on an idle lane boundary.
- Arbitrates requests from source A and source B.
- Changes ownership only when the current owner is in LP-11 with HS clock/data disabled.
- Inserts a guard interval of forced LP-11 between owners.
- Drives the switch select (i_state) and per-source grants.

Parameters:
GUARD_CYCLES, 16, byte_clk cycles of forced LP-11 between release and new grant (min 1)
CNT_W, 8, width of guard/timeout counters; must hold GUARD_CYCLES and TIMEOUT_CYCLES
TIMEOUT_CYCLES, 200, cycles a waiting requester tolerates a non-releasing owner (used only with the optional feature)

Ports:
byte_clk  in  1  byte clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
req_a  in  1  source A requests lane ownership (level)
req_b  in  1  source B requests lane ownership (level)
hs_clk_en_a / hs_clk_en_b  in  1  each  HS clock enable of each source
hs_data_en_a / hs_data_en_b  in  1  each  HS data enable of each source
lp0_out_a / lp0_out_b  in  2  each  lane-0 LP levels of each source
i_state  out  1  switch select; 0 = source A, 1 = source B
grant_a / grant_b  out  1  each  source currently owns the lane
force_lp11  out  1  high during handover; datapath drives LP-11 and gates HS enables
busy  out  1  handover in progress (any state other than OWN)
timeout_err  out  1  sticky; optional feature only, else tied 0

Behaviour:
Reset values:
- i_state=0, grant_a=1, grant_b=0, force_lp11=0, busy=0, timeout_err=0.
- State = OWN; counters = 0.
- Reset is asynchronous and may occur mid-handover. It returns ownership to A immediately; no guard interval is applied.

Definitions:
- owner = i_state; other = !i_state.
- owner_idle = owner hs_clk_en==0 && hs_data_en==0 && lp0_out==2'b11, all sampled in the same cycle.

States:
- OWN: grant[owner]=1. If req[other] && !req[owner] && owner_idle, go to DRAIN next cycle. Otherwise stay.
- DRAIN: grant[owner]=0, force_lp11=1, busy=1.
  - If owner_idle holds for 2 consecutive cycles, go to GUARD with counter cleared.
  - If idle drops, restart the 2-cycle check.
  - If req[other] drops while in DRAIN, abort: return to OWN with the same owner; its grant reasserts the next cycle.
- GUARD: force_lp11=1, both grants 0. Counter increments each cycle; at GUARD_CYCLES-1, go to SWITCH. Requests are ignored here; no abort.
- SWITCH: one cycle. i_state toggles (registered), force_lp11=1, then go to OWN. The new owner's grant rises the cycle after i_state changes.

Timing and rules:
- Handover latency, from the OWN cycle where the switch condition is true to the new grant: 1 + 2 + GUARD_CYCLES + 1 + 1 cycles (GUARD_CYCLES=16 gives 21).
- Simultaneous req_a && req_b while the owner still requests: the owner keeps the lane. The owner must drop req to hand over.
- No request from either source: the current owner retains the lane; there is no return to A.
- Outputs are registered; no combinational input-to-output paths.
- Counters saturate; they never wrap.

Optional Feature:
DFS_FORCE_TIMEOUT_EN
- Enabled: in OWN, count cycles where req[other]=1 and req[owner]=1.
  - The counter resets when either request drops.
  - On reaching TIMEOUT_CYCLES with owner_idle, go to DRAIN as if released and set timeout_err (sticky until reset).
  - The owner's req is then ignored through SWITCH.
- Disabled: no timeout counter; timeout_err is constant 0; a non-releasing owner holds the lane indefinitely.

Decomposition:
- Shared package dfs_pkg:
  - State encoding typedef: OWN, DRAIN, GUARD, SWITCH.
  - Constant LP11 = 2'b11.
  - Constant DRAIN_IDLE_CYCLES = 2.
- One sub-module, dfs_idle_detect: per-source idle qualifier, instantiated twice, selected by i_state.
- Counters and FSM stay in the top module.

Test Plan:
1. Reset release, no requests -> i_state=0, grant_a=1, grant_b=0, force_lp11=0 for 50 cycles.
2. A idle (hs_*=0, lp0_out_a=11), req_a=0, req_b=1 at cycle 10 -> force_lp11 high at 11; i_state=1 at 30; grant_b=1 at 31 (GUARD_CYCLES=16).
3. Same as 2, but req_b drops during DRAIN -> back to OWN, i_state stays 0, grant_a reasserts the next cycle, no guard executed.
4. req_b=1, A idle but req_a held high for 500 cycles, feature disabled -> no switch, timeout_err=0. Feature enabled, TIMEOUT_CYCLES=200 -> DRAIN entered after 200 cycles, timeout_err=1, i_state=1 at handover end.
5. hs_data_en_a toggles 1 for a single cycle during DRAIN -> 2-cycle idle check restarts; GUARD entry delayed accordingly.
6. reset_n asserted during GUARD while owner=B -> asynchronously i_state=0, grant_a=1, force_lp11=0, busy=0.
